// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - op codes, FSM state encoding and iterative-op classifier for alu_mc
package alu_pkg;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SLTU  = 4'b0011;
    localparam logic [3:0] OP_SLL   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SRA   = 4'b1000;
    localparam logic [3:0] OP_MUL   = 4'b1001;
    localparam logic [3:0] OP_MULHU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1100;
    localparam logic [3:0] OP_REM   = 4'b1101;
    localparam logic [3:0] OP_XOR   = 4'b1110;
    localparam logic [3:0] OP_NOR   = 4'b1111;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// rtl/alu_mc_if.sv - request/response bundle between the EX-stage control and alu_mc
interface alu_mc_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, op, a, b,
        input  in_ready, out_valid, result, zero, carry, overflow
    );

    modport slave (
        input  in_valid, op, a, b,
        output in_ready, out_valid, result, zero, carry, overflow
    );

endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - one-bit-per-cycle shift-add multiplier and restoring divider
module alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] acc_next
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_b;
    logic               r_div;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [2*WIDTH-1:0] w_div_next;

    // Accumulator is {hi, lo}: multiply shifts the product in from the top,
    // divide shifts the dividend out of lo while quotient bits fill in behind it.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_b};
        w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                              : {1'b0, r_acc[2*WIDTH-1:1]};
        w_trial    = r_acc[2*WIDTH-1:WIDTH-1];
        w_diff     = w_trial - {1'b0, r_b};
        w_ge       = ~w_diff[WIDTH];
        w_div_next = {(w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                      r_acc[WIDTH-2:0], w_ge};
        acc_next   = r_div ? w_div_next : w_mul_next;
        last       = (r_cnt == CW'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_b   <= '0;
            r_div <= 1'b0;
            r_cnt <= '0;
        end else if (load) begin
            r_acc <= {{WIDTH{1'b0}}, a};
            r_b   <= b;
            r_div <= div_mode;
            r_cnt <= CW'(WIDTH);
        end else if (step) begin
            r_acc <= acc_next;
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: FSM, single-cycle ops and registered result/flags
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_op;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_carry;
    logic               r_overflow;
    logic               r_out_valid;

    logic               w_load;
    logic               w_step;
    logic               w_out_en;
    logic               w_last;
    logic               w_div_zero;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_defined;
    logic               w_carry;
    logic               w_ovf;

    assign w_div_zero = ((bus.op == OP_DIV) || (bus.op == OP_REM)) && (bus.b == '0);

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        w_out_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (is_iter(bus.op) && !w_div_zero) begin
                        w_load       = 1'b1;
                        w_state_next = S_RUN;
                    end else begin
                        w_out_en = 1'b1;
                    end
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_out_en     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // In RUN the result comes from the final iteration's next accumulator so it
    // lands on the same edge the counter reaches zero.
    always_comb begin
        w_shamt   = bus.b[SHW-1:0];
        w_add     = {1'b0, bus.a} + {1'b0, bus.b};
        w_sub     = {1'b0, bus.a} + {1'b0, ~bus.b} + (WIDTH+1)'(1);
        w_res     = '0;
        w_defined = 1'b1;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        if (r_state == S_RUN) begin
            case (r_op)
                OP_MUL:   w_res = w_acc_next[WIDTH-1:0];
                OP_MULHU: w_res = w_acc_next[2*WIDTH-1:WIDTH];
                OP_DIV:   w_res = w_acc_next[WIDTH-1:0];
                default:  w_res = w_acc_next[2*WIDTH-1:WIDTH];
            endcase
        end else begin
            case (bus.op)
                OP_AND:  w_res = bus.a & bus.b;
                OP_OR:   w_res = bus.a | bus.b;
                OP_XOR:  w_res = bus.a ^ bus.b;
                OP_NOR:  w_res = ~(bus.a | bus.b);
                OP_ADD: begin
                    w_res   = w_add[WIDTH-1:0];
                    w_carry = w_add[WIDTH];
                    w_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                              (w_add[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SUB: begin
                    w_res   = w_sub[WIDTH-1:0];
                    w_carry = w_sub[WIDTH];
                    w_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                              (w_sub[WIDTH-1] != bus.a[WIDTH-1]);
                end
                OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
                OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
                OP_SLL:  w_res = bus.a << w_shamt;
                OP_SRL:  w_res = bus.a >> w_shamt;
                OP_SRA:  w_res = WIDTH'($signed(bus.a) >>> w_shamt);
                OP_DIV:  w_res = '1;
                OP_REM:  w_res = bus.a;
                default: w_defined = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= w_out_en;
            if (w_load)
                r_op <= bus.op;
            if (w_out_en) begin
                r_result   <= w_res;
                r_zero     <= w_defined & ~|w_res;
                r_carry    <= w_carry;
                r_overflow <= w_ovf;
            end
        end
    end

    alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_load),
        .step     (w_step),
        .div_mode ((bus.op == OP_DIV) || (bus.op == OP_REM)),
        .a        (bus.a),
        .b        (bus.b),
        .last     (w_last),
        .acc_next (w_acc_next)
    );

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.carry     = r_carry;
    assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - directed scoreboard bench for alu_mc
module tb_alu_mc;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         o;
        string        name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t q[$];
    exp_t m_e;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out_valid: got result %h with no pending op", bus.result);
            end else begin
                m_e = q.pop_front();
                if ({bus.result, bus.zero, bus.carry, bus.overflow} !== {m_e.res, m_e.z, m_e.c, m_e.o}) begin
                    errors++;
                    $display("FAIL %s: got res=%h z=%b c=%b o=%b expected res=%h z=%b c=%b o=%b",
                             m_e.name, bus.result, bus.zero, bus.carry, bus.overflow,
                             m_e.res, m_e.z, m_e.c, m_e.o);
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input logic z, input logic c, input logic o,
                         input int lat_exp, input bit poke, input string name);
        exp_t e;
        int lat;
        int busy;
        e.res = res; e.z = z; e.c = c; e.o = o; e.name = name;
        chk({name, "_ready_before"}, {31'd0, bus.in_ready}, 32'd1);
        q.push_back(e);
        bus.in_valid = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        busy = 0;
        while (lat < 100) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid) break;
            if (!bus.in_ready) busy++;
            lat++;
            if (poke && lat == 5) begin
                bus.in_valid = 1'b1;
                bus.op = 4'b0010;
                bus.a = 32'd1;
                bus.b = 32'd1;
            end
        end
        bus.in_valid = 1'b0;
        chk({name, "_latency"}, W'(lat), W'(lat_exp));
        chk({name, "_busy_cycles"}, W'(busy), W'(lat_exp));
    endtask

    initial begin
        int seen;
        bus.in_valid = 1'b0;
        bus.op = 4'd0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(negedge clk);
        chk("reset_result", bus.result, 32'd0);
        chk("reset_flags", {28'd0, bus.zero, bus.carry, bus.overflow, bus.out_valid}, 32'd0);
        chk("reset_ready", {31'd0, bus.in_ready}, 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(4'b0010, 32'hFFFF_FFFF, 32'd1,          32'd0,          1, 1, 0, 0, 0, "add_wrap");
        issue(4'b0010, 32'h7FFF_FFFF, 32'd1,          32'h8000_0000,  0, 0, 1, 0, 0, "add_ovf");
        issue(4'b0111, 32'hFFFF_FFFF, 32'd1,          32'd1,          0, 0, 0, 0, 0, "slt");
        issue(4'b0011, 32'hFFFF_FFFF, 32'd1,          32'd0,          1, 0, 0, 0, 0, "sltu");
        issue(4'b0110, 32'd5,         32'd5,          32'd0,          1, 1, 0, 0, 0, "sub_eq");
        issue(4'b0110, 32'h8000_0000, 32'd1,          32'h7FFF_FFFF,  0, 1, 1, 0, 0, "sub_ovf");
        issue(4'b1000, 32'h8000_0000, 32'd36,         32'hF800_0000,  0, 0, 0, 0, 0, "sra");
        issue(4'b0101, 32'h8000_0000, 32'd36,         32'h0800_0000,  0, 0, 0, 0, 0, "srl");
        issue(4'b0100, 32'd1,         32'h21,         32'd2,          0, 0, 0, 0, 0, "sll");
        issue(4'b1011, 32'd0,         32'd0,          32'd0,          0, 0, 0, 0, 0, "undef");
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_0FF0,  32'h0000_00F0,  0, 0, 0, 0, 0, "and");
        issue(4'b0001, 32'h0000_F0F0, 32'h0000_0FF0,  32'h0000_FFF0,  0, 0, 0, 0, 0, "or");
        issue(4'b1110, 32'h0000_F0F0, 32'h0000_0FF0,  32'h0000_FF00,  0, 0, 0, 0, 0, "xor");
        issue(4'b1111, 32'd0,         32'd0,          32'hFFFF_FFFF,  0, 0, 0, 0, 0, "nor");
        issue(4'b1001, 32'h0001_0000, 32'h0001_0000,  32'd0,          1, 0, 0, W, 1, "mul");
        issue(4'b1010, 32'h0001_0000, 32'h0001_0000,  32'd1,          0, 0, 0, W, 0, "mulhu");
        issue(4'b1001, 32'd12345,     32'd678,        32'd8369910,    0, 0, 0, W, 0, "mul_small");
        issue(4'b1100, 32'd100,       32'd7,          32'd14,         0, 0, 0, W, 0, "div");
        issue(4'b1101, 32'd100,       32'd7,          32'd2,          0, 0, 0, W, 0, "rem");
        issue(4'b1100, 32'hFFFF_FFFF, 32'h0001_0000,  32'h0000_FFFF,  0, 0, 0, W, 0, "div_big");
        issue(4'b1100, 32'd123,       32'd0,          32'hFFFF_FFFF,  0, 0, 0, 0, 0, "div_zero");
        issue(4'b1101, 32'd9,         32'd0,          32'd9,          0, 0, 0, 0, 0, "rem_zero");

        bus.in_valid = 1'b1;
        bus.op = 4'b1100;
        bus.a = 32'd100;
        bus.b = 32'd7;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_result", bus.result, 32'd0);
        chk("abort_flags", {28'd0, bus.zero, bus.carry, bus.overflow, bus.out_valid}, 32'd0);
        chk("abort_ready", {31'd0, bus.in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("abort_no_out_valid", W'(seen), 32'd0);
        issue(4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 0, "add_after_reset");

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", W'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU, successor to the single-cycle combinational ALU in the CPU datapath. Adds registered outputs, width parametrisation, shifts, signed/unsigned compare, carry/overflow flags, and iterative unsigned multiply/divide behind a valid/ready handshake. Sits in the EX stage; the control unit stalls on `in_ready` low.

## Interface
- `WIDTH`, 32, datapath width in bits; must be ≥ 4 and a power of two.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; not overridden).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operation request.
- `in_ready` output 1: block can accept; equals (state == IDLE).
- `op` input 4: operation code.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `out_valid` output 1: one-cycle pulse, result/flags are new.
- `result` output WIDTH: registered result, held until next `out_valid`.
- `zero` output 1: `~|result` for defined ops, 0 for undefined ops.
- `carry` output 1: ADD carry-out; SUB carry-out of a+~b+1 (1 = no borrow); else 0.
- `overflow` output 1: signed overflow for ADD/SUB; else 0.

## Operation
- Op codes: AND 0000, OR 0001, ADD 0010, SLTU 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111 (signed), SRA 1000, MUL 1001 (low WIDTH bits), MULHU 1010 (high WIDTH bits, unsigned), DIV 1100 (unsigned quotient), REM 1101 (unsigned remainder), XOR 1110, NOR 1111.
- Undefined codes (1011): accepted as single-cycle; result 0, zero 0, carry 0, overflow 0.
- Shifts use `b[SHW-1:0]` only; upper bits of `b` are ignored.
- SLT/SLTU yield 1 or 0, zero-extended to WIDTH.
- MUL/MULHU: shift-add over a 2·WIDTH accumulator, one bit per cycle.
- DIV/REM: restoring division, one quotient bit per cycle.
- Divide by zero is detected at accept and completes in a single cycle: DIV → all ones, REM → `a`.
- States:
  - IDLE: accept when `in_valid`. A single-cycle op (or divide by zero) registers outputs and pulses `out_valid`, staying in IDLE. MUL/MULHU/DIV/REM latch operands, load counter = WIDTH, and go to RUN.
  - RUN: one iteration per cycle with counter decrement. On the counter 1→0 edge, register outputs, pulse `out_valid`, and return to IDLE.
- `in_valid` while in RUN is ignored and not queued.
- Reset (async, any time, including mid-RUN): state IDLE, counter 0, `result` 0, `zero` 0, `carry` 0, `overflow` 0, `out_valid` 0. `in_ready` is 1 after reset. An aborted operation produces no `out_valid`.

## Timing
- Single-cycle ops: accept at edge k; `out_valid` high during cycle k..k+1, i.e. latency 1. Back-to-back issue every cycle is allowed.
- Iterative ops: accept at edge k; `in_ready` low for exactly WIDTH cycles; outputs registered at edge k+WIDTH; `out_valid` high for the following cycle.
- `in_ready` is 1 in the `out_valid` cycle of an iterative op, so a new op may be accepted there.
- Outputs change only at reset or on an edge that raises `out_valid`.

## Structure
- `alu_pkg`: the 4-bit op-code localparams, an `is_iter(op)` function, and the state encoding (IDLE, RUN).
- Sub-module `alu_iter`: shift-add/restoring-divide datapath with operand registers, 2·WIDTH accumulator, counter, and `step`/`load` controls.
- `alu_mc` holds the FSM, the single-cycle combinational ops, and the output registers.

## Test plan
- ADD a=0xFFFFFFFF, b=1 → result 0, zero 1, carry 1, overflow 0; `out_valid` one cycle after accept. ADD 0x7FFFFFFF+1 → 0x80000000, overflow 1.
- SLT a=0xFFFFFFFF, b=1 → 1; SLTU with the same operands → 0. SUB 5−5 → 0, zero 1, carry 1.
- SRA a=0x80000000, b=36 → 0xF8000000 (shift 4). SRL with the same operands → 0x08000000. Undefined op 1011 → result 0, zero 0.
- MUL 0x00010000×0x00010000 → 0; MULHU → 1. `in_ready` low for 32 cycles; `out_valid` at edge 33 after accept; an `in_valid` pulse during RUN is ignored.
- DIV 100/7 → 14, REM → 2 (33-edge latency). DIV by 0 → 0xFFFFFFFF and REM 9/0 → 9, both with 1-cycle latency.
- Assert `rst_n` low 10 cycles into a DIV → all outputs 0 immediately. After release: no `out_valid`, `in_ready` 1, and a following ADD 2+3 → 5 with 1-cycle latency.
